// File: rtl/decade_seq_ctrl.sv
// Stopwatch / event-count sequencer: prescaled tick, rippled BCD digits,
// start/stop/clear command FSM and terminal-count detection.
`timescale 1ns/1ps
module decade_seq_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 5
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic [4*DIGITS-1:0] target,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                tick_out,
    output logic                running,
    output logic                done,
    output logic                overflow
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] psc_q, psc_d;
    logic [CW-1:0] cnt_q, cnt_d, inc_cnt;
    logic          carry, tgt_ok;
    logic          tick_q, tick_d, done_q, done_d, ovf_q, ovf_d, run_q;

    // Ripple increment; carry out of the top digit means all digits were 9.
    always_comb begin
        carry   = 1'b1;
        inc_cnt = cnt_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (cnt_q[4*d +: 4] == 4'd9) begin
                    inc_cnt[4*d +: 4] = 4'd0;
                end else begin
                    inc_cnt[4*d +: 4] = cnt_q[4*d +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // A zero target or one holding a non-BCD digit can never be reached.
    always_comb begin
        tgt_ok = (target != '0);
        for (int d = 0; d < DIGITS; d++) begin
            if (target[4*d +: 4] > 4'd9) tgt_ok = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            psc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_d = S_RUN;
                        psc_d   = '0;
                    end
                end
                S_RUN: begin
                    // stop freezes everything, including a tick due this cycle
                    if (stop) begin
                        state_d = S_PAUSE;
                    end else if (psc_q == PSC_MAX) begin
                        psc_d  = '0;
                        cnt_d  = inc_cnt;
                        tick_d = 1'b1;
                        ovf_d  = carry;
                        if (tgt_ok && (inc_cnt == target)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        psc_d = psc_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (start && !stop) state_d = S_RUN;
                end
                S_DONE: begin
                    if (start && !stop) begin
                        state_d = S_RUN;
                        psc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            psc_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            run_q   <= (state_d == S_RUN);
        end
    end

    assign bcd_out  = cnt_q;
    assign tick_out = tick_q;
    assign running  = run_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_decade_seq_ctrl.sv
// Scoreboard bench: expected ticks are queued with their cycle number and
// popped by per-instance monitors whenever tick_out is seen.
`timescale 1ns/1ps
module tb_decade_seq_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 0, stop_a = 0, clear_a = 0;
    logic [15:0] target_a = '0, bcd_a;
    logic        tick_a, run_a, done_a, ovf_a;

    logic        start_b = 0, stop_b = 0, clear_b = 0;
    logic [7:0]  target_b = '0, bcd_b;
    logic        tick_b, run_b, done_b, ovf_b;

    decade_seq_ctrl #(.DIGITS(4), .PRESCALE(5)) u_a (
        .clk_in(clk), .reset(reset), .start(start_a), .stop(stop_a), .clear(clear_a),
        .target(target_a), .bcd_out(bcd_a), .tick_out(tick_a), .running(run_a),
        .done(done_a), .overflow(ovf_a));

    decade_seq_ctrl #(.DIGITS(2), .PRESCALE(1)) u_b (
        .clk_in(clk), .reset(reset), .start(start_b), .stop(stop_b), .clear(clear_b),
        .target(target_b), .bcd_out(bcd_b), .tick_out(tick_b), .running(run_b),
        .done(done_b), .overflow(ovf_b));

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic        dn;
        logic        ov;
        logic        run;
    } exp_t;

    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int   cyc = 0, nchk = 0, nerr = 0;
    int   k, m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic push_a(int c, int v, logic dn, logic rn);
        exp_t e;
        e.cyc = c; e.bcd = to_bcd(v); e.dn = dn; e.ov = 1'b0; e.run = rn;
        qa.push_back(e);
    endtask

    task automatic push_b(int c, int v, logic ov);
        exp_t e;
        e.cyc = c; e.bcd = to_bcd(v); e.dn = 1'b0; e.ov = ov; e.run = 1'b1;
        qb.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (tick_a) begin
                chk("a_tick_expected", 32'(qa.size() != 0), 1);
                if (qa.size() != 0) begin
                    ea = qa.pop_front();
                    chk("a_tick_cycle", cyc, ea.cyc);
                    chk("a_bcd", {16'd0, bcd_a}, {16'd0, ea.bcd});
                    chk("a_done", done_a, ea.dn);
                    chk("a_overflow", ovf_a, ea.ov);
                    chk("a_running", run_a, ea.run);
                end
            end else begin
                chk("a_pulse_without_tick", {30'd0, done_a, ovf_a}, 0);
            end
            if (tick_b) begin
                chk("b_tick_expected", 32'(qb.size() != 0), 1);
                if (qb.size() != 0) begin
                    eb = qb.pop_front();
                    chk("b_tick_cycle", cyc, eb.cyc);
                    chk("b_bcd", {24'd0, bcd_b}, {16'd0, eb.bcd});
                    chk("b_done", done_b, eb.dn);
                    chk("b_overflow", ovf_b, eb.ov);
                    chk("b_running", run_b, eb.run);
                end
            end else begin
                chk("b_pulse_without_tick", {30'd0, done_b, ovf_b}, 0);
            end
        end
    end

    initial begin
        #2 reset = 1'b0;
        step(2);
        chk("rst_bcd_a", {16'd0, bcd_a}, 0);
        chk("rst_flags_a", {28'd0, tick_a, run_a, done_a, ovf_a}, 0);
        chk("rst_bcd_b", {24'd0, bcd_b}, 0);
        chk("rst_flags_b", {28'd0, tick_b, run_b, done_b, ovf_b}, 0);
        reset = 1'b1;
        step(2);

        // count to 0x0012, done on the 12th tick
        target_a = 16'h0012;
        start_a = 1; k = cyc + 1;
        for (int i = 1; i <= 12; i++) push_a(k + 5*i, i, i == 12, i != 12);
        step(1); start_a = 0;
        chk("t1_running", run_a, 1);
        step(65);
        chk("t1_hold_bcd", {16'd0, bcd_a}, 32'h12);
        chk("t1_running_low", run_a, 0);

        // restart from DONE, pause with prescaler frozen at 3, resume
        start_a = 1; k = cyc + 1;
        step(1); start_a = 0;
        step(3); stop_a = 1;
        step(1); stop_a = 0;
        chk("t2_paused_running", run_a, 0);
        step(20);
        chk("t2_restart_bcd", {16'd0, bcd_a}, 0);
        start_a = 1; m = cyc + 1;
        push_a(m + 2, 1, 0, 1);
        step(1); start_a = 0;
        chk("t2_resumed_running", run_a, 1);
        step(2); clear_a = 1;
        step(1); clear_a = 0;
        chk("t2_clear_bcd", {16'd0, bcd_a}, 0);
        chk("t2_clear_running", run_a, 0);

        // invalid target; start+stop+clear at 0x0037 -> IDLE
        target_a = 16'h00A1;
        start_a = 1; k = cyc + 1;
        for (int i = 1; i <= 37; i++) push_a(k + 5*i, i, 0, 1);
        step(1); start_a = 0;
        step(185);
        start_a = 1; stop_a = 1; clear_a = 1;
        step(1); start_a = 0; stop_a = 0; clear_a = 0;
        chk("t4_clear_bcd", {16'd0, bcd_a}, 0);
        chk("t4_clear_running", run_a, 0);
        chk("t4_clear_no_tick", tick_a, 0);
        step(10);

        // start+stop at 0x0037 -> PAUSE, then free-run past 0x0101
        start_a = 1; k = cyc + 1;
        for (int i = 1; i <= 37; i++) push_a(k + 5*i, i, 0, 1);
        step(1); start_a = 0;
        step(185);
        start_a = 1; stop_a = 1;
        step(1); start_a = 0; stop_a = 0;
        chk("t4_pause_running", run_a, 0);
        chk("t4_pause_bcd", {16'd0, bcd_a}, 32'h37);
        chk("t4_pause_no_tick", tick_a, 0);
        step(10);
        start_a = 1; m = cyc + 1;
        for (int i = 38; i <= 105; i++) push_a(m + 5*(i - 37), i, 0, 1);
        step(1); start_a = 0;
        step(342); clear_a = 1;
        step(1); clear_a = 0;

        // async reset in the tick cycle of 0x0099
        target_a = 16'h0000;
        start_a = 1; k = cyc + 1;
        for (int i = 1; i <= 98; i++) push_a(k + 5*i, i, 0, 1);
        step(1); start_a = 0;
        step(495);
        chk("t5_pre_bcd", {16'd0, bcd_a}, 32'h99);
        chk("t5_pre_tick", tick_a, 1);
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_bcd", {16'd0, bcd_a}, 0);
        chk("t5_rst_flags", {28'd0, tick_a, run_a, done_a, ovf_a}, 0);
        step(2); reset = 1'b1;
        step(10);
        chk("t5_idle_bcd", {16'd0, bcd_a}, 0);
        chk("t5_idle_running", run_a, 0);
        start_a = 1; k = cyc + 1;
        for (int i = 1; i <= 3; i++) push_a(k + 5*i, i, 0, 1);
        step(1); start_a = 0;
        step(15); clear_a = 1;
        step(1); clear_a = 0;

        // 2 digits, tick every cycle, wrap 99 -> 00 with overflow
        target_b = 8'h00;
        start_b = 1; k = cyc + 1;
        for (int i = 1; i <= 103; i++) push_b(k + i, i % 100, i == 100);
        step(1); start_b = 0;
        step(103); clear_b = 1;
        step(1); clear_b = 0;
        chk("t3_clear_bcd", {24'd0, bcd_b}, 0);
        chk("t3_clear_no_tick", tick_b, 0);

        step(5);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
